// File: rtl/sum_sequencer.sv
// sum_sequencer: streams up to MAX_CHUNKS 16-operand chunks through an external
// sigma16 tree and adder, accumulating a single signed-magnitude sum.
`default_nettype none

`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

module sum_sequencer #(
    parameter int N          = `N,
    parameter int F          = `F,
    parameter int MAX_CHUNKS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   num_chunks,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data [0:15],
    output logic [N-1:0] tree_a  [0:15],
    input  logic [N-1:0] tree_c,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N-1:0] add_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] MAXC = 5'(MAX_CHUNKS);

    state_t       state, state_nx;
    logic [4:0]   acc_cnt;
    logic [4:0]   add_cnt;
    logic [4:0]   nchunks;
    logic [N-1:0] acc;
    logic [N-1:0] chunk_q [0:15];
    logic         chunk_v;
    logic         xfer;
    logic         start_ok;

    assign start_ok  = start && (num_chunks != 4'd0) && ({1'b0, num_chunks} <= MAXC);
    assign in_ready  = (state == ACCUM) && (acc_cnt < nchunks);
    assign xfer      = in_valid && in_ready;

    assign tree_a    = chunk_q;
    assign add_a     = acc;
    assign add_b     = tree_c;
    assign out_data  = acc;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start_ok) state_nx = ACCUM;
            ACCUM: if (xfer && ((acc_cnt + 5'd1) == nchunks)) state_nx = DRAIN;
            // The last chunk's add lands on the edge that leaves DRAIN.
            DRAIN: if (chunk_v && ((add_cnt + 5'd1) == nchunks)) state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            acc_cnt <= '0;
            add_cnt <= '0;
            nchunks <= '0;
            chunk_v <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < 16; i++) chunk_q[i] <= '0;
        end else begin
            state   <= state_nx;
            cfg_err <= (state == IDLE) && start && !start_ok;
            chunk_v <= xfer;
            if (xfer) begin
                chunk_q <= in_data;
                acc_cnt <= acc_cnt + 5'd1;
            end
            if (chunk_v) begin
                acc     <= add_c;
                add_cnt <= add_cnt + 5'd1;
            end
            if ((state == IDLE) && start_ok) begin
                nchunks <= {1'b0, num_chunks};
                acc     <= '0;
                acc_cnt <= '0;
                add_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sum_sequencer.sv
// Bench for sum_sequencer: models the external tree/adder and checks sums
// against an integer reference of all accepted operands.
`default_nettype none

`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

module tb_sum_sequencer;

    localparam int N = `N;
    localparam int F = `F;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   num_chunks = 4'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data [0:15];
    logic [N-1:0] tree_a  [0:15];
    logic [N-1:0] tree_c;
    logic [N-1:0] add_a, add_b, add_c;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         busy;
    logic         cfg_err;

    int checks   = 0;
    int failures = 0;

    sum_sequencer #(.N(N), .F(F), .MAX_CHUNKS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tree_a(tree_a), .tree_c(tree_c), .add_a(add_a), .add_b(add_b),
        .add_c(add_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic int sm2i(input logic [N-1:0] v);
        int m;
        m = int'({1'b0, v[N-2:0]});
        return v[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] i2sm(input int x);
        if (x < 0) return {1'b1, (N-1)'(-x)};
        return {1'b0, (N-1)'(x)};
    endfunction

    // Behavioural external sigma16 tree and adder (zero always +0).
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += sm2i(tree_a[i]);
        tree_c = i2sm(s);
    end
    assign add_c = i2sm(sm2i(add_a) + sm2i(add_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // pmode 0: random operands; pmode 1: chunk 0 all +1.0, later chunks all -0.5.
    task automatic run_sum(input int nc, input int gap, input int hold,
                           input int pmode, input int fixed_exp, input string tag);
        int sum;
        logic [N-1:0] v;
        logic [N-1:0] held;
        sum = 0;
        start = 1'b1;
        num_chunks = nc[3:0];
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < nc; k++) begin
            for (int l = 0; l < 16; l++) begin
                if (pmode == 1) v = (k == 0) ? N'(16'h0100) : N'(16'h8080);
                else            v = {1'($urandom_range(0, 1)), (N-1)'($urandom_range(0, 127))};
                in_data[l] = v;
                sum += sm2i(v);
            end
            in_valid = 1'b1;
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (k < nc - 1) begin
                for (int g = 0; g < gap; g++) begin
                    start = 1'b1;
                    num_chunks = 4'd0;
                    chk({tag, "_gap_ready"}, 32'(in_ready), 32'd1);
                    @(negedge clk);
                    start = 1'b0;
                    chk({tag, "_no_cfg_err"}, 32'(cfg_err), 32'd0);
                end
            end
        end
        chk({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(i2sm(sum)));
        if (fixed_exp >= 0) chk({tag, "_out_fixed"}, 32'(out_data), 32'(fixed_exp));
        held = i2sm(sum);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_release_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) in_data[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_cfg_err",   32'(cfg_err), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);

        run_sum(1, 0, 0, 1, 32'h1000, "one_chunk");
        run_sum(2, 0, 0, 1, 32'h0800, "two_chunk");
        run_sum(3, 2, 0, 0, -1, "gap3");
        run_sum(2, 0, 5, 0, -1, "hold5");

        start = 1'b1;
        num_chunks = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("nc0_cfg_err",  32'(cfg_err), 32'd1);
        chk("nc0_busy",     32'(busy), 32'd0);
        chk("nc0_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("nc0_pulse_end", 32'(cfg_err), 32'd0);
        start = 1'b1;
        num_chunks = 4'd9;
        @(negedge clk);
        start = 1'b0;
        chk("nc9_cfg_err",  32'(cfg_err), 32'd1);
        chk("nc9_busy",     32'(busy), 32'd0);
        chk("nc9_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("nc9_pulse_end", 32'(cfg_err), 32'd0);

        start = 1'b1;
        num_chunks = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int l = 0; l < 16; l++) in_data[l] = N'(16'h0040);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",      32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready), 32'd0);
        chk("midrst_out_data",  32'(out_data), 32'd0);
        chk("midrst_tree_a0",   32'(tree_a[0]), 32'd0);
        run_sum(1, 0, 0, 0, -1, "post_rst");

        for (int r = 0; r < 4; r++)
            run_sum(int'($urandom_range(1, 8)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 0, -1, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
